// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-RAM arbiter.
//   - arb_state_e : arbiter FSM encoding (idle / issue / response)
//   - PORT_CPU / PORT_DBG : requester ids (core load/store path, loader/debug master)
//   - DMEM_ADDR_W / DMEM_DATA_W : default RAM geometry
//   - sat_inc16 : saturating 16-bit increment used by the statistics counters
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 6;
  localparam int unsigned DMEM_DATA_W = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin winner select with burst-lock priority update.
// Purely combinational.
//   req0_i, req1_i   : pending requests from port 0 / port 1
//   prio_i           : port favoured when both request
//   grant_o          : winning port id (only meaningful when a request is pending)
//   win_i            : port that won the access now completing
//   win_lock_i       : that winner's lock flag, as latched at grant
//   other_req_i      : the other port is pending while the access completes
//   burst_cnt_i      : consecutive locked grants held against a pending port
//   prio_o           : next priority
//   burst_cnt_o      : next burst count
module rr_pick2 #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic             prio_i,
  output logic             grant_o,
  input  logic             win_i,
  input  logic             win_lock_i,
  input  logic             other_req_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  output logic             prio_o,
  output logic [CNT_W-1:0] burst_cnt_o
);

  always_comb begin
    if (req0_i && req1_i) begin
      grant_o = prio_i;
    end else begin
      grant_o = req1_i;
    end
  end

  always_comb begin
    prio_o      = ~win_i;
    burst_cnt_o = '0;
    if (win_lock_i) begin
      if (!other_req_i) begin
        // Nobody waiting: a locking winner keeps priority indefinitely.
        prio_o = win_i;
      end else if (32'(burst_cnt_i) < MAX_BURST - 1) begin
        prio_o      = win_i;
        burst_cnt_o = burst_cnt_i + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data RAM between the core load/store path (port 0)
// and a loader/debug master (port 1). Each access runs IDLE -> ISSUE -> RESP, with a
// one-cycle ack in RESP. Round-robin arbitration with optional short burst lock.
//   clk, reset        : clock, synchronous active-low reset
//   r*_req/lock/we    : request, priority-retention request, write select
//   r*_addr/wdata     : access address and write data
//   r*_ack/rdata      : one-cycle completion pulse and read data (0 for writes)
//   mem_we/addr/wdata : RAM write enable, address, write data
//   mem_rdata         : RAM read data, combinational from mem_addr
//   busy              : FSM not idle
//   stat_g0/g1/conf   : grant and conflict counters, built only with DMEM_ARB_STATS_EN
// Build option: define DMEM_ARB_STATS_EN to build the saturating statistics counters;
// otherwise stat_* are tied to 0.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMEM_ADDR_W,
  parameter int unsigned DATA_W    = DMEM_DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_lock,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_lock,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [15:0]       stat_g0,
  output logic [15:0]       stat_g1,
  output logic [15:0]       stat_conf
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              win_q, win_d;
  logic              lock_q, lock_d;
  logic              r0_ack_q, r0_ack_d;
  logic              r1_ack_q, r1_ack_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

  logic             grant;
  logic             other_req;
  logic             pick_prio;
  logic [CNT_W-1:0] pick_cnt;

  assign other_req = (win_q == PORT_CPU) ? r1_req : r0_req;

  rr_pick2 #(
    .MAX_BURST(MAX_BURST),
    .CNT_W    (CNT_W)
  ) u_pick (
    .req0_i     (r0_req),
    .req1_i     (r1_req),
    .prio_i     (prio_q),
    .grant_o    (grant),
    .win_i      (win_q),
    .win_lock_i (lock_q),
    .other_req_i(other_req),
    .burst_cnt_i(burst_cnt_q),
    .prio_o     (pick_prio),
    .burst_cnt_o(pick_cnt)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    burst_cnt_d = burst_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    win_d       = win_q;
    lock_d      = lock_q;
    r0_ack_d    = r0_ack_q;
    r1_ack_d    = r1_ack_q;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
    case (state_q)
      StIdle: begin
        if (r0_req || r1_req) begin
          win_d   = grant;
          we_d    = (grant == PORT_CPU) ? r0_we    : r1_we;
          addr_d  = (grant == PORT_CPU) ? r0_addr  : r1_addr;
          wdata_d = (grant == PORT_CPU) ? r0_wdata : r1_wdata;
          lock_d  = (grant == PORT_CPU) ? r0_lock  : r1_lock;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Capture read data at the edge that commits the write, so the ack and
        // data leave together from registers in RESP.
        if (win_q == PORT_CPU) begin
          r0_ack_d   = 1'b1;
          r0_rdata_d = we_q ? '0 : mem_rdata;
        end else begin
          r1_ack_d   = 1'b1;
          r1_rdata_d = we_q ? '0 : mem_rdata;
        end
        state_d = StResp;
      end
      StResp: begin
        r0_ack_d    = 1'b0;
        r1_ack_d    = 1'b0;
        r0_rdata_d  = '0;
        r1_rdata_d  = '0;
        prio_d      = pick_prio;
        burst_cnt_d = pick_cnt;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      burst_cnt_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      win_q       <= 1'b0;
      lock_q      <= 1'b0;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      burst_cnt_q <= burst_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      win_q       <= win_d;
      lock_q      <= lock_d;
      r0_ack_q    <= r0_ack_d;
      r1_ack_q    <= r1_ack_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  // Reset gates the write so an access interrupted in ISSUE never reaches the RAM.
  assign mem_we    = (state_q == StIssue) & we_q & reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_g0_q, stat_g0_d;
  logic [15:0] stat_g1_q, stat_g1_d;
  logic [15:0] stat_conf_q, stat_conf_d;

  // Grant counters step with the ack being set, so they match the visible ack count.
  always_comb begin
    stat_g0_d   = stat_g0_q;
    stat_g1_d   = stat_g1_q;
    stat_conf_d = stat_conf_q;
    if (state_q == StIssue) begin
      if (win_q == PORT_CPU) begin
        stat_g0_d = sat_inc16(stat_g0_q);
      end else begin
        stat_g1_d = sat_inc16(stat_g1_q);
      end
    end
    if (state_q == StIdle && r0_req && r1_req) begin
      stat_conf_d = sat_inc16(stat_conf_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_g0_q   <= '0;
      stat_g1_q   <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_g0_q   <= stat_g0_d;
      stat_g1_q   <= stat_g1_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign stat_g0   = stat_g0_q;
  assign stat_g1   = stat_g1_q;
  assign stat_conf = stat_conf_q;
`else
  assign stat_g0   = '0;
  assign stat_g1   = '0;
  assign stat_conf = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural RAM.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 64;
`ifdef DMEM_ARB_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  localparam logic [63:0] WrData = 64'hDEADBEEF_00000001;

  logic              clk = 1'b0;
  logic              reset;
  logic              r0_req, r0_lock, r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_ack;
  logic [DATA_W-1:0] r0_rdata;
  logic              r1_req, r1_lock, r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_ack;
  logic [DATA_W-1:0] r1_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [15:0]       stat_g0, stat_g1, stat_conf;

  logic [63:0] ram [64] = '{default: 64'h0};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .r0_req   (r0_req),
    .r0_lock  (r0_lock),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_ack   (r0_ack),
    .r0_rdata (r0_rdata),
    .r1_req   (r1_req),
    .r1_lock  (r1_lock),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_ack   (r1_ack),
    .r1_rdata (r1_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .stat_g0  (stat_g0),
    .stat_g1  (stat_g1),
    .stat_conf(stat_conf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // One uncontended access on a single port; checks issue, ack and return to idle.
  task automatic single(input logic port, input logic we, input logic [5:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input string tag);
    if (port) begin
      r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata;
    end else begin
      r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata;
    end
    tick();
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_issue_we"}, 64'(mem_we), 64'(we));
    check({tag, "_issue_addr"}, 64'(mem_addr), 64'(addr));
    tick();
    check({tag, "_ack"}, 64'(port ? r1_ack : r0_ack), 64'd1);
    check({tag, "_rdata"}, port ? r1_rdata : r0_rdata, exp_rdata);
    check({tag, "_resp_we"}, 64'(mem_we), 64'd0);
    if (port) r1_req = 1'b0; else r0_req = 1'b0;
    tick();
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Both ports held requesting; checks the winner of each access in turn.
  task automatic contend(input logic winners [], input string tag);
    for (int k = 0; k < winners.size(); k++) begin
      tick();
      tick();
      check($sformatf("%s_ack0_%0d", tag, k), 64'(r0_ack), 64'(winners[k] == 1'b0));
      check($sformatf("%s_ack1_%0d", tag, k), 64'(r1_ack), 64'(winners[k] == 1'b1));
      if (k == winners.size() - 1) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    logic rr_order [] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic burst_order [] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b0;
    r0_req = 1'b0; r0_lock = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_lock = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;

    // Reset held with a pending request.
    r0_req = 1'b1;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_ack0", 64'(r0_ack), 64'd0);
    check("rst_rdata0", r0_rdata, 64'd0);
    check("rst_stat_g0", 64'(stat_g0), 64'd0);
    reset = 1'b1;
    tick();
    check("rel_ack_c1", 64'(r0_ack), 64'd0);
    tick();
    check("rel_ack_c2", 64'(r0_ack), 64'd1);
    r0_req = 1'b0;
    tick();
    check("rel_idle", 64'(r0_ack), 64'd0);

    // Write then read back through port 0.
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 6'd5; r0_wdata = WrData;
    tick();
    check("wr_mem_wdata", mem_wdata, WrData);
    tick();
    r0_req = 1'b0;
    tick();
    check("wr_ram5", ram[5], WrData);
    single(1'b0, 1'b0, 6'd5, 64'd0, WrData, "rd5");

    // Round-robin under continuous contention.
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 6'd5;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 6'd5;
    contend(rr_order, "rr");
    check("rr_stat_conf", 64'(stat_conf), StatsEn ? 64'd4 : 64'd0);
    check("rr_stat_g0", 64'(stat_g0), StatsEn ? 64'd2 : 64'd0);
    check("rr_stat_g1", 64'(stat_g1), StatsEn ? 64'd2 : 64'd0);

    // Burst lock on port 1 with port 0 pending.
    do_reset();
    r1_lock = 1'b1;
    r0_req = 1'b1;
    r1_req = 1'b1;
    contend(burst_order, "burst");
    r1_lock = 1'b0;
    check("burst_stat_g1", 64'(stat_g1), StatsEn ? 64'd4 : 64'd0);

    // Lock with no contention: ten back-to-back 3-cycle accesses.
    r0_lock = 1'b1;
    for (int k = 0; k < 10; k++) begin
      single(1'b0, 1'b1, 6'(k + 16), 64'(k), 64'd0, $sformatf("lk%0d", k));
    end
    r0_lock = 1'b0;
    check("lk_ram25", ram[25], 64'd9);

    // Reset during ISSUE of a port-1 write.
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 6'd9; r1_wdata = 64'hCAFE_F00D_1234_5678;
    tick();
    check("mid_issue_we", 64'(mem_we), 64'd1);
    check("mid_issue_addr", 64'(mem_addr), 64'd9);
    reset = 1'b0;
    #1;
    check("mid_gate_we", 64'(mem_we), 64'd0);
    tick();
    check("mid_ram9", ram[9], 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_ack1", 64'(r1_ack), 64'd0);
    r1_req = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_ack1_after", 64'(r1_ack), 64'd0);
    check("mid_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
